// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Holds the FSM state encoding, default parameters and counter sizing.
package instr_fetch_ctrl_pkg;

  localparam int unsigned DEF_WIDTH         = 32;
  localparam int unsigned DEF_ROM_ADDR_BITS = 12;
  localparam int unsigned DEF_RESET_PC      = 0;
  localparam int unsigned DEF_DBG_WAIT      = 3;

  // S_DBG: debug owns the ROM port this cycle; S_ACK: dbg_ack is high.
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_DBG  = 2'd2,
    S_ACK  = 2'd3
  } fetch_state_e;

  // Width of a counter that must reach max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, delivers one registered instruction per cycle,
// and shares the ROM read port with a debug reader under a bounded wait.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned ROM_ADDR_BITS = DEF_ROM_ADDR_BITS,
  parameter int unsigned RESET_PC      = DEF_RESET_PC,
  parameter int unsigned DBG_WAIT      = DEF_DBG_WAIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [WIDTH-1:0]         rom_data,
  input  logic                     stall,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ROM_ADDR_BITS-1:0] redirect_addr,
  output logic                     if_valid,
  output logic [WIDTH-1:0]         if_instr,
  output logic [ROM_ADDR_BITS-1:0] if_pc,
  input  logic                     dbg_req,
  input  logic [ROM_ADDR_BITS-1:0] dbg_addr,
  output logic                     dbg_ack,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int unsigned AW    = ROM_ADDR_BITS;
  localparam int unsigned DW    = WIDTH;
  localparam int unsigned CNT_W = cnt_width(DBG_WAIT);

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [DW-1:0]    if_instr_q, if_instr_d;
  logic [AW-1:0]    if_pc_q, if_pc_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic [DW-1:0]    dbg_data_q, dbg_data_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic core_fetch;
  logic arb_state;
  logic grant;
  logic core_state;

  // Debug steals the ROM only while in S_DBG; the PC drives it otherwise.
  assign rom_addr = (state_q == S_DBG) ? dbg_addr : pc_q;

  assign core_state = (state_q == S_RUN) || (state_q == S_ACK);
  assign arb_state  = (state_q == S_RUN) || (state_q == S_HALT);
  assign grant      = arb_state && dbg_req &&
                      (stall || halt || (wait_q == CNT_W'(DBG_WAIT)));
  assign core_fetch = core_state && !stall && !halt && !redirect_valid;

  // Next-state, PC, fetch register and arbitration logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    dbg_ack_d  = 1'b0;
    dbg_data_d = dbg_data_q;
    wait_d     = wait_q;

    unique case (state_q)
      S_RUN: begin
        if (grant) begin
          state_d = S_DBG;
        end else if (halt) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (grant) begin
          state_d = S_DBG;
        end else if (!halt) begin
          state_d = S_RUN;
        end
      end
      S_DBG: begin
        dbg_data_d = rom_data;
        state_d    = S_ACK;
      end
      S_ACK: begin
        state_d = halt ? S_HALT : S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (core_fetch) begin
      if_instr_d = rom_data;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + AW'(1);
    end

    if (core_state && halt) begin
      if_valid_d = 1'b0;
    end

    // A debug cycle leaves a bubble unless decode is stalled anyway.
    if ((state_q == S_DBG) && !stall) begin
      if_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d       = redirect_addr;
      if_valid_d = 1'b0;
    end

    if (!dbg_req || grant) begin
      wait_d = '0;
    end else if (state_q == S_RUN) begin
      wait_d = wait_q + CNT_W'(1);
    end

    dbg_ack_d = (state_d == S_ACK);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= AW'(RESET_PC);
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
      wait_q     <= wait_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign dbg_ack  = dbg_ack_q;
  assign dbg_data = dbg_data_q;

endmodule
